// File: rtl/keypad_mov.sv
// 4x4 matrix keypad scanner with per-direction debounce and opposing-key
// conflict resolution, producing the registered u/d/l/r movement vector.

module keypad_mov_deb #(
  parameter int DEB_FRAMES = 4
) (
  input  logic sys_clk,
  input  logic RST_N,
  input  logic frame_done,
  input  logic key,
  output logic db
);
  logic [3:0] cnt;

  // Any agreeing frame restarts the count, so only a sustained change flips db.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (frame_done) begin
      if (key == db) begin
        cnt <= '0;
      end else if (cnt == 4'(DEB_FRAMES - 1)) begin
        db  <= key;
        cnt <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

module keypad_mov #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_FRAMES = 4,
  parameter int KEY_UP     = 4,
  parameter int KEY_DOWN   = 6,
  parameter int KEY_LEFT   = 1,
  parameter int KEY_RIGHT  = 9
) (
  input  logic       sys_clk,
  input  logic       RST_N,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] mov,
  output logic       mov_new
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [3:0][3:0] KEY_MAP = {4'(KEY_UP), 4'(KEY_DOWN), 4'(KEY_LEFT), 4'(KEY_RIGHT)};

  logic [3:0]    sync1, sync2;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col;
  logic [15:0]   frame, frame_next;
  logic          tick, frame_done, upd_pend;
  logic [3:0]    db, res;

  // Rows are inverted on entry so the synchronizer resets to "not pressed".
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~row_in;
      sync2 <= sync1;
    end
  end

  assign tick       = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_done = tick && (col == 2'd3);
  // Debounce sees the complete frame including the column-3 rows being stored now.
  assign frame_next = {sync2, frame[11:0]};

  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
      col     <= '0;
      col_out <= 4'b1110;
      frame   <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) begin
        frame[{col, 2'b00} +: 4] <= sync2;
        col     <= col + 2'd1;
        col_out <= ~(4'b0001 << (col + 2'd1));
      end
    end
  end

  genvar d;
  generate
    for (d = 0; d < 4; d++) begin : g_deb
      keypad_mov_deb #(.DEB_FRAMES(DEB_FRAMES)) u_deb (
        .sys_clk    (sys_clk),
        .RST_N      (RST_N),
        .frame_done (frame_done),
        .key        (frame_next[KEY_MAP[d]]),
        .db         (db[d])
      );
    end
  endgenerate

  // Opposing keys on one axis cancel; the two axes resolve independently.
  assign res[3:2] = (db[3] & db[2]) ? 2'b00 : db[3:2];
  assign res[1:0] = (db[1] & db[0]) ? 2'b00 : db[1:0];

  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      upd_pend <= 1'b0;
      mov      <= '0;
      mov_new  <= 1'b0;
    end else begin
      upd_pend <= frame_done;
      mov_new  <= 1'b0;
      if (upd_pend) begin
        mov     <= res;
        mov_new <= |(res & ~mov);
      end
    end
  end
endmodule

// File: tb/tb_keypad_mov.sv
// Directed bench for keypad_mov: reset, scan order, press/release latency,
// bounce rejection, conflict resolution and mid-frame reset.

module tb_keypad_mov;
  localparam int SD = 8;
  localparam int DF = 3;
  localparam int FR = 4 * SD;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    logic [3:0]  mov;
    int          pulses;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  row_in, col_out, mov;
  logic        mov_new;
  logic [15:0] keys = '0;
  int          checks = 0, errors = 0;
  vec_t        vecs[$];

  always #5 sys_clk = ~sys_clk;

  // Pull-up rows, pulled low by a pressed key whose column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_out[c] && keys[c*4+r]) row_in[r] = 1'b0;
  end

  keypad_mov #(.SCAN_DIV(SD), .DEB_FRAMES(DF), .KEY_UP(4), .KEY_DOWN(6),
               .KEY_LEFT(1), .KEY_RIGHT(9)) dut (
    .sys_clk (sys_clk),
    .RST_N   (RST_N),
    .row_in  (row_in),
    .col_out (col_out),
    .mov     (mov),
    .mov_new (mov_new)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic add(input logic [15:0] k, input int f, input logic [3:0] m, input int p);
    vec_t v;
    v.keys = k; v.frames = f; v.mov = m; v.pulses = p;
    vecs.push_back(v);
  endtask

  initial begin
    add(16'h0200, 3, 4'b0001, 1);   // right press
    add(16'h0000, 3, 4'b0000, 0);   // right release
    for (int i = 0; i < 10; i++)    // key 4 bouncing frame by frame
      add((i % 2 == 0) ? 16'h0010 : 16'h0000, 1, 4'b0000, 0);
    add(16'h0202, 3, 4'b0000, 0);   // left+right conflict
    add(16'h0212, 3, 4'b1000, 1);   // add up
    add(16'h0210, 3, 4'b1001, 1);   // drop left, right reappears
    add(16'h0250, 3, 4'b0001, 0);   // up+down conflict
    add(16'h0240, 3, 4'b0101, 1);   // drop up, down reappears
    add(16'h0000, 3, 4'b0000, 0);
    add(16'h0012, 3, 4'b1010, 1);   // diagonal up+left
    add(16'h0000, 2, 4'b1010, 0);   // one frame short of release
    add(16'h0012, 1, 4'b1010, 0);   // agreeing frame restarts count
    add(16'h0000, 2, 4'b1010, 0);
    add(16'h0000, 1, 4'b0000, 0);

    // Reset held with key 9 pressed
    keys  = 16'h0200;
    RST_N = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      chk("rst_col", col_out, 4'b1110);
      chk("rst_mov", mov, 4'b0000);
      chk("rst_new", mov_new, 0);
    end
    RST_N = 1'b1;   // cycle 0
    chk("scan_c0", col_out, 4'b1110);
    cyc(7);  chk("scan_c7",  col_out, 4'b1110);
    cyc(1);  chk("scan_c8",  col_out, 4'b1101);
    cyc(8);  chk("scan_c16", col_out, 4'b1011);
    cyc(8);  chk("scan_c24", col_out, 4'b0111);
    cyc(8);  chk("scan_c32", col_out, 4'b1110);
    cyc(64); chk("press_96_mov", mov, 4'b0000);
             chk("press_96_new", mov_new, 0);
    cyc(1);  chk("press_97_mov", mov, 4'b0001);
             chk("press_97_new", mov_new, 1);
    cyc(1);  chk("press_98_mov", mov, 4'b0001);
             chk("press_98_new", mov_new, 0);

    // Mid-column-2 reset (cycle 116 of the frame sequence)
    cyc(18);
    #1 RST_N = 1'b0;
    #1;
    chk("mrst_mov", mov, 4'b0000);
    chk("mrst_col", col_out, 4'b1110);
    chk("mrst_new", mov_new, 0);
    cyc(3);
    RST_N = 1'b1;
    cyc(96); chk("mrst_96_mov", mov, 4'b0000);
    cyc(1);  chk("mrst_97_mov", mov, 4'b0001);
             chk("mrst_97_new", mov_new, 1);

    // Table-driven frame sequences from a fresh reset
    RST_N = 1'b0;
    keys  = '0;
    cyc(2);
    RST_N = 1'b1;
    cyc(1);
    foreach (vecs[i]) begin
      int p;
      p    = 0;
      keys = vecs[i].keys;
      for (int c = 0; c < vecs[i].frames * FR; c++) begin
        @(negedge sys_clk);
        if (mov_new) p++;
      end
      chk($sformatf("vec%0d_mov", i), mov, vecs[i].mov);
      chk($sformatf("vec%0d_pulses", i), p, vecs[i].pulses);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_mov.md
# keypad_mov

Matrix-keypad scanner and debouncer that produces the 4-bit movement vector consumed by the character-movement block (`mov`, order u d l r). It drives the 4×4 keypad columns, samples the rows, and builds a full 16-key frame every scan cycle. It debounces the four direction keys, resolves opposing-direction conflicts, and presents a stable, registered `mov` level plus a one-cycle new-press pulse.

## Interface
Parameters:
- SCAN_DIV, 50000: `sys_clk` cycles per column dwell; must be ≥ 4.
- DEB_FRAMES, 4: consecutive disagreeing frames required to flip a debounced key; range 1–15.
- KEY_UP, 4: key index (col*4+row) mapped to up.
- KEY_DOWN, 6: key index mapped to down.
- KEY_LEFT, 1: key index mapped to left.
- KEY_RIGHT, 9: key index mapped to right.

Ports:
- sys_clk  in  1  system clock; the block's only clock.
- RST_N  in  1  asynchronous, active-low reset.
- row_in  in  4  keypad rows, active-low, asynchronous to `sys_clk`.
- col_out  out  4  column drive, one-hot active-low.
- mov  out  4  debounced direction levels: [3] up, [2] down, [1] left, [0] right.
- mov_new  out  1  one-cycle pulse when any `mov` bit rises.

## Operation
- Row synchronizer: `row_in` passes through a 2-flop synchronizer and is inverted internally, so 1 means pressed.
- Scan counter: `div_cnt` counts 0..SCAN_DIV-1. The cycle where `div_cnt` = SCAN_DIV-1 is a "tick".
- On each tick:
  - Store the synced rows into `frame[col*4 +: 4]`.
  - Advance `col` (2 bits, wraps 3→0).
  - Update `col_out` = ~(1<<`col`) on the same edge.
- Frame completion: the tick that samples col 3 is `frame_done`. `frame` then holds all 16 keys, with index = col*4+row.
- Debounce, per direction d (4 independent units), each with a debounced bit `db[d]` and a counter `cnt[d]` (4 bits). On `frame_done`:
  - If `frame[KEY_d]` equals `db[d]`, clear `cnt[d]` to 0.
  - Otherwise, if `cnt[d]` = DEB_FRAMES-1, set `db[d]` = `frame[KEY_d]` and clear `cnt[d]`.
  - Otherwise, increment `cnt[d]`.
- Conflict resolution, applied to `db` before registering:
  - `db` up and down both 1 → `mov[3:2]` = 00.
  - `db` left and right both 1 → `mov[1:0]` = 00.
  - Axes are resolved independently; diagonals pass through (e.g. up+right → 1001).
- `mov` is registered and updates only on the cycle after `frame_done`.
- `mov_new` = 1 for exactly one cycle when (new `mov` & ~old `mov`) ≠ 0, coincident with the `mov` update.
- Non-direction keys are scanned but ignored.

## Timing
- Reset values, applied asynchronously while RST_N = 0:
  - Outputs: `col_out` = 1110, `mov` = 0000, `mov_new` = 0.
  - Internal: `col` = 0, `div_cnt` = 0, `frame` = 0, all `db` = 0, all `cnt` = 0, synchronizer flops = 0 (not pressed).
- Scan rate: frame period = 4*SCAN_DIV cycles. The column settles for SCAN_DIV cycles before sampling; synchronizer latency is 2 cycles, within the dwell.
- Press latency: the key must be held from the start of a frame. `mov` rises 1 cycle after the DEB_FRAMES-th consecutive `frame_done` showing it pressed.
- Release latency: symmetric, DEB_FRAMES frames plus 1 cycle.
- Bounce rejection: any agreeing frame restarts the count, so a glitch shorter than DEB_FRAMES frames never reaches `mov`.
- Simultaneous events:
  - Two directions debouncing on the same frame update in the same cycle.
  - A conflict appearing makes both bits of that axis 0 in that update. No `mov_new` is raised for them.
- Conflict release: when one key of a conflicting pair is released, the remaining key's bit rises at that update and `mov_new` pulses.
- Reset mid-frame: the scan restarts at column 0 with full SCAN_DIV dwell after RST_N deasserts. The first valid frame completes 4*SCAN_DIV cycles after deassertion, counted from the first `div_cnt` = 0 cycle.
- Between updates, `mov` holds; the downstream stage may sample it at any rate.

## Test plan
Bench uses SCAN_DIV=8, DEB_FRAMES=3 (frame = 32 cycles), rows modelled as pull-ups pulled low when the pressed key's column is driven low.
- Reset: hold RST_N=0 for 5 cycles with key 9 pressed → `col_out`=1110, `mov`=0000, `mov_new`=0 throughout; after release `col_out` steps 1110→1101→1011→0111→1110 every 8 cycles.
- Right press: hold key 9 from the first frame → `mov`=0001 one cycle after the 3rd `frame_done` (cycle 97 after reset deassert), `mov_new` high exactly that one cycle.
- Bounce: toggle key 4 pressed/released on alternate frames for 10 frames → `mov` stays 0000, `mov_new` never pulses.
- Conflicts: hold keys 1 and 9 → `mov`=0000. Add key 4 → 1000 with `mov_new`. Release key 1 → 1001 after 3 frames, with `mov_new`.
- Release: from `mov`=0001, release key 9 → `mov`=0000 one cycle after the 3rd subsequent `frame_done`, no `mov_new`.
- Mid-operation reset: `mov`=0001, assert RST_N mid-column-2 → `mov`=0000 and `col_out`=1110 immediately. Keep key 9 held after deassert → `mov`=0001 again after 3 full frames +1 cycle.
